// File: rtl/packet_sink_stats.sv
// Ejection-side sink for one network output port.
// Buffers arriving packets in a small FIFO and drains them at a programmable
// rate to model a slow consumer. For each drained packet it checks the
// destination and accumulates latency statistics through a two-stage
// pipeline. sink_full is the backpressure seen by the network.

package packet_sink_pkg;

    localparam int NET_PORTS  = 16;
    localparam int NET_DEST_W = $clog2(NET_PORTS);

    // Network packet. The sink uses valid, dest, measure and data[23:0];
    // data[23:0] carries the injection timestamp.
    typedef struct packed {
        logic                  valid;
        logic [NET_DEST_W-1:0] dest;
        logic                  measure;
        logic [31:0]           data;
    } packet_t;

endpackage

module packet_sink_stats
    import packet_sink_pkg::*;
#(
    parameter int port_no = 0,
    parameter int PORTS   = 16,
    parameter int DEPTH   = 8     // power of two, at least 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] timestamp,
    input  logic [7:0]  drain_period,
    input  packet_t     pkt_in,
    output logic        sink_full,
    output logic [15:0] rx_count,
    output logic [15:0] meas_count,
    output logic [39:0] lat_sum,
    output logic [23:0] lat_max,
    output logic        misroute_error,
    output logic        overflow_error
);

    localparam int DEST_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0]  OCC_ZERO = OCC_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [DEST_W-1:0] DEST_EXP = DEST_W'(port_no);

    // One FIFO entry: only what the drain side needs.
    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic              measure;
        logic [23:0]       stamp;
    } entry_t;

    // Saturating accumulate of a zero-extended latency into the 40-bit sum.
    function automatic logic [39:0] sat_add40(input logic [39:0] acc, input logic [23:0] inc);
        logic [40:0] sum;
        sum = {1'b0, acc} + {17'd0, inc};
        if (sum[40]) begin
            sat_add40 = {40{1'b1}};
        end else begin
            sat_add40 = sum[39:0];
        end
    endfunction

    // Storage and pointers
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [7:0]        dcnt_q, dcnt_d;

    // Stage 1 of the statistics pipeline
    logic              s1_vld_q, s1_vld_d;
    logic [23:0]       s1_lat_q, s1_lat_d;
    logic              s1_meas_q, s1_meas_d;
    logic              s1_mis_q, s1_mis_d;

    // Statistics registers
    logic [15:0]       rx_count_q, rx_count_d;
    logic [15:0]       meas_count_q, meas_count_d;
    logic [39:0]       lat_sum_q, lat_sum_d;
    logic [23:0]       lat_max_q, lat_max_d;
    logic              misroute_q, misroute_d;
    logic              overflow_q, overflow_d;

    // Decoded control
    logic              empty_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    entry_t            wr_entry_s;
    entry_t            head_s;
    logic [23:0]       head_lat_s;
    logic              head_mis_s;

    // Upper data bits carry no meaning for the sink.
    logic              unused_data_s;
    assign unused_data_s = ^pkt_in.data[31:24];

    // Accept/drop/pop decisions, all from pre-edge occupancy.
    always_comb begin
        empty_s   = (occ_q == OCC_ZERO);
        sink_full = (occ_q == FULL_OCC);
        push_s    = pkt_in.valid & ~sink_full;
        drop_s    = pkt_in.valid & sink_full;
        // >= rather than == so a drain_period lowered below dcnt still pops.
        pop_s     = ~empty_s & (dcnt_q >= drain_period);
    end

    // Entry formatting on the write side and latency/route check on the head.
    always_comb begin
        wr_entry_s.dest    = DEST_W'(pkt_in.dest);
        wr_entry_s.measure = pkt_in.measure;
        wr_entry_s.stamp   = pkt_in.data[23:0];
        head_s             = mem_q[rd_ptr_q];
        // Unsigned 24-bit subtraction handles timestamp wrap naturally.
        head_lat_s         = timestamp - head_s.stamp;
        head_mis_s         = (head_s.dest != DEST_EXP);
    end

    // FIFO pointers and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Drain pacing: park at drain_period while empty so the first packet
    // after idle pops as soon as it becomes visible.
    always_comb begin
        dcnt_d = dcnt_q;
        if (empty_s) begin
            dcnt_d = drain_period;
        end else if (pop_s) begin
            dcnt_d = 8'd0;
        end else begin
            dcnt_d = dcnt_q + 8'd1;
        end
    end

    // Stage 1 captures the popped entry's latency, measure bit and route check.
    always_comb begin
        s1_vld_d  = pop_s;
        s1_lat_d  = s1_lat_q;
        s1_meas_d = s1_meas_q;
        s1_mis_d  = s1_mis_q;
        if (pop_s) begin
            s1_lat_d  = head_lat_s;
            s1_meas_d = head_s.measure;
            s1_mis_d  = head_mis_s;
        end else begin
            s1_lat_d  = s1_lat_q;
            s1_meas_d = s1_meas_q;
            s1_mis_d  = s1_mis_q;
        end
    end

    // Accept-side counters and sticky overflow flag.
    always_comb begin
        rx_count_d   = rx_count_q;
        meas_count_d = meas_count_q;
        overflow_d   = overflow_q | drop_s;
        if (push_s) begin
            rx_count_d = rx_count_q + 16'd1;
            if (pkt_in.measure) begin
                meas_count_d = meas_count_q + 16'd1;
            end else begin
                meas_count_d = meas_count_q;
            end
        end else begin
            rx_count_d   = rx_count_q;
            meas_count_d = meas_count_q;
        end
    end

    // Stage 2: fold stage-1 results into sum/max; misroute counts even unmeasured.
    always_comb begin
        lat_sum_d  = lat_sum_q;
        lat_max_d  = lat_max_q;
        misroute_d = misroute_q | (s1_vld_q & s1_mis_q);
        if (s1_vld_q && s1_meas_q) begin
            lat_sum_d = sat_add40(lat_sum_q, s1_lat_q);
            if (s1_lat_q > lat_max_q) begin
                lat_max_d = s1_lat_q;
            end else begin
                lat_max_d = lat_max_q;
            end
        end else begin
            lat_sum_d = lat_sum_q;
            lat_max_d = lat_max_q;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

    // All control and statistics state, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            occ_q        <= {OCC_W{1'b0}};
            dcnt_q       <= 8'd0;
            s1_vld_q     <= 1'b0;
            s1_lat_q     <= 24'd0;
            s1_meas_q    <= 1'b0;
            s1_mis_q     <= 1'b0;
            rx_count_q   <= 16'd0;
            meas_count_q <= 16'd0;
            lat_sum_q    <= 40'd0;
            lat_max_q    <= 24'd0;
            misroute_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            dcnt_q       <= dcnt_d;
            s1_vld_q     <= s1_vld_d;
            s1_lat_q     <= s1_lat_d;
            s1_meas_q    <= s1_meas_d;
            s1_mis_q     <= s1_mis_d;
            rx_count_q   <= rx_count_d;
            meas_count_q <= meas_count_d;
            lat_sum_q    <= lat_sum_d;
            lat_max_q    <= lat_max_d;
            misroute_q   <= misroute_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rx_count       = rx_count_q;
    assign meas_count     = meas_count_q;
    assign lat_sum        = lat_sum_q;
    assign lat_max        = lat_max_q;
    assign misroute_error = misroute_q;
    assign overflow_error = overflow_q;

endmodule

// File: tb/tb_packet_sink_stats.sv
// Self-checking bench for packet_sink_stats. Expected latencies are pushed
// into a scoreboard queue as packets are driven; a monitor pops them as
// lat_sum advances and checks the increment and the running maximum.
module tb_packet_sink_stats;
    import packet_sink_pkg::*;

    localparam int PORT_NO = 0;
    localparam int PORTS   = 16;
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] timestamp;
    logic [7:0]  drain_period;
    packet_t     pkt_in;
    logic        sink_full;
    logic [15:0] rx_count;
    logic [15:0] meas_count;
    logic [39:0] lat_sum;
    logic [23:0] lat_max;
    logic        misroute_error;
    logic        overflow_error;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q [$];
    logic [39:0] mon_prev_sum;
    logic [23:0] mon_max;

    packet_sink_stats #(.port_no(PORT_NO), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .timestamp      (timestamp),
        .drain_period   (drain_period),
        .pkt_in         (pkt_in),
        .sink_full      (sink_full),
        .rx_count       (rx_count),
        .meas_count     (meas_count),
        .lat_sum        (lat_sum),
        .lat_max        (lat_max),
        .misroute_error (misroute_error),
        .overflow_error (overflow_error)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs and timestamp change 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        timestamp = timestamp + 24'd1;
    endtask

    task automatic send(input logic [NET_DEST_W-1:0] dest, input logic meas, input logic [23:0] stamp);
        pkt_in.valid   = 1'b1;
        pkt_in.dest    = dest;
        pkt_in.measure = meas;
        pkt_in.data    = {8'hA5, stamp};
    endtask

    task automatic idle();
        pkt_in.valid   = 1'b0;
        pkt_in.measure = 1'b0;
    endtask

    task automatic apply_reset(input logic [7:0] dp);
        idle();
        rst = 1'b1;
        drain_period = dp;
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
        step();
    endtask

    // Scoreboard consumer: every lat_sum step must match the next expected latency.
    task automatic monitor();
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_sum = 40'd0;
                mon_max      = 24'd0;
            end else if (lat_sum !== mon_prev_sum) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: lat_sum moved %0d -> %0d, no packet expected", mon_prev_sum, lat_sum);
                end else begin
                    e = exp_q.pop_front();
                    if (lat_sum !== mon_prev_sum + {16'd0, e}) begin
                        failures++;
                        $display("FAIL sb_lat: lat_sum=%0d expected=%0d (latency %0d)", lat_sum, mon_prev_sum + {16'd0, e}, e);
                    end
                    if (e > mon_max) mon_max = e;
                    checks++;
                    if (lat_max !== mon_max) begin
                        failures++;
                        $display("FAIL sb_max: lat_max=%0d expected=%0d", lat_max, mon_max);
                    end
                end
                mon_prev_sum = lat_sum;
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (rx_count !== 16'd0)       begin failures++; $display("FAIL rst_rx: got %0d want 0", rx_count); end
        checks++; if (meas_count !== 16'd0)     begin failures++; $display("FAIL rst_meas: got %0d want 0", meas_count); end
        checks++; if (lat_sum !== 40'd0)        begin failures++; $display("FAIL rst_sum: got %0d want 0", lat_sum); end
        checks++; if (lat_max !== 24'd0)        begin failures++; $display("FAIL rst_max: got %0d want 0", lat_max); end
        checks++; if (sink_full !== 1'b0)       begin failures++; $display("FAIL rst_full: got %0b want 0", sink_full); end
        checks++; if ({misroute_error, overflow_error} !== 2'b00)
            begin failures++; $display("FAIL rst_err: got %b want 00", {misroute_error, overflow_error}); end
    endtask

    task automatic test_single();
        apply_reset(8'd0);
        timestamp = 24'd105;
        send(NET_DEST_W'(PORT_NO), 1'b1, 24'd100);
        exp_q.push_back(24'd6);
        step();                              // cycle 106: pop
        idle();
        checks++; if (rx_count !== 16'd1)   begin failures++; $display("FAIL single_rx: got %0d want 1", rx_count); end
        checks++; if (meas_count !== 16'd1) begin failures++; $display("FAIL single_meas: got %0d want 1", meas_count); end
        step();                              // cycle 107
        checks++; if (lat_sum !== 40'd0)    begin failures++; $display("FAIL single_early: lat_sum=%0d want 0 at 107", lat_sum); end
        step();                              // cycle 108
        checks++; if (lat_sum !== 40'd6)    begin failures++; $display("FAIL single_sum: got %0d want 6", lat_sum); end
        checks++; if (lat_max !== 24'd6)    begin failures++; $display("FAIL single_max: got %0d want 6", lat_max); end
        checks++; if ({misroute_error, overflow_error} !== 2'b00)
            begin failures++; $display("FAIL single_err: got %b want 00", {misroute_error, overflow_error}); end
    endtask

    task automatic test_wrap();
        apply_reset(8'd0);
        timestamp = 24'd2;
        send(NET_DEST_W'(PORT_NO), 1'b1, 24'hFFFFFE);
        exp_q.push_back(24'd5);
        step();                              // pop at timestamp 3
        idle();
        step();
        step();
        checks++; if (lat_sum !== 40'd5) begin failures++; $display("FAIL wrap_sum: got %0d want 5", lat_sum); end
        checks++; if (lat_max !== 24'd5) begin failures++; $display("FAIL wrap_max: got %0d want 5", lat_max); end
    endtask

    // Valid every cycle with drain_period=3: pops at cycles 1,5,9,... so
    // packet k (pushed at cycle k) sees latency 1+4k-k.
    task automatic test_backpressure();
        apply_reset(8'd3);
        for (int c = 0; c < 12; c++) begin
            if (c == 10) begin
                checks++; if (sink_full !== 1'b0) begin failures++; $display("FAIL bp_full7: got %0b want 0", sink_full); end
            end
            if (c == 11) begin
                checks++; if (sink_full !== 1'b1) begin failures++; $display("FAIL bp_full8: got %0b want 1", sink_full); end
            end
            send(NET_DEST_W'(PORT_NO), 1'b1, timestamp);
            if (c < 11) exp_q.push_back(24'(1 + 3 * c));
            step();
        end
        idle();                              // cycle 12
        checks++; if (overflow_error !== 1'b1) begin failures++; $display("FAIL bp_ovf: got %0b want 1", overflow_error); end
        checks++; if (rx_count !== 16'd11)     begin failures++; $display("FAIL bp_rx: got %0d want 11", rx_count); end
        checks++; if (meas_count !== 16'd11)   begin failures++; $display("FAIL bp_meas: got %0d want 11", meas_count); end
        step();                              // cycle 13: still full, pop cycle
        checks++; if (sink_full !== 1'b1) begin failures++; $display("FAIL bp_hold: got %0b want 1", sink_full); end
        step();                              // cycle 14
        checks++; if (sink_full !== 1'b0) begin failures++; $display("FAIL bp_release: got %0b want 0", sink_full); end
        for (int i = 0; i < 35; i++) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain: %0d packets never observed", exp_q.size()); end
        checks++; if (lat_sum !== 40'd176) begin failures++; $display("FAIL bp_sum: got %0d want 176", lat_sum); end
        checks++; if (lat_max !== 24'd31)  begin failures++; $display("FAIL bp_max: got %0d want 31", lat_max); end
    endtask

    task automatic test_well_behaved();
        int sent;
        sent = 0;
        apply_reset(8'd3);
        for (int c = 0; c < 40; c++) begin
            if (!sink_full) begin
                send(NET_DEST_W'(PORT_NO), 1'b0, timestamp);
                sent++;
            end else begin
                idle();
            end
            step();
        end
        idle();
        checks++; if (sent != 18)                begin failures++; $display("FAIL wb_sent: got %0d want 18", sent); end
        checks++; if (overflow_error !== 1'b0)   begin failures++; $display("FAIL wb_ovf: got %0b want 0", overflow_error); end
        checks++; if (rx_count !== 16'(sent))    begin failures++; $display("FAIL wb_rx: got %0d want %0d", rx_count, sent); end
        checks++; if (meas_count !== 16'd0)      begin failures++; $display("FAIL wb_meas: got %0d want 0", meas_count); end
    endtask

    // Fill to DEPTH-1, then push only in pop cycles. Data offsets of 16k
    // make every latency distinct so ordering errors show up.
    task automatic test_push_pop();
        int k;
        k = 0;
        apply_reset(8'd3);
        for (int c = 0; c < 26; c++) begin
            checks++; if (sink_full !== 1'b0) begin failures++; $display("FAIL pp_full: cycle %0d got %0b want 0", c, sink_full); end
            if (c <= 9 || c == 13 || c == 17 || c == 21) begin
                send(NET_DEST_W'(PORT_NO), 1'b1, timestamp - 24'(16 * k));
                exp_q.push_back(24'(1 + 4 * k - c + 16 * k));
                k++;
            end else begin
                idle();
            end
            step();
        end
        idle();
        for (int i = 0; i < 30; i++) step();
        checks++; if (rx_count !== 16'd13) begin failures++; $display("FAIL pp_rx: got %0d want 13", rx_count); end
        checks++; if (exp_q.size() != 0)   begin failures++; $display("FAIL pp_drain: %0d packets never observed", exp_q.size()); end
        checks++; if (lat_max !== 24'd220) begin failures++; $display("FAIL pp_max: got %0d want 220", lat_max); end
    endtask

    task automatic test_misroute();
        apply_reset(8'd0);
        send(NET_DEST_W'(PORT_NO + 1), 1'b0, timestamp - 24'd3);
        step();                              // pop cycle
        idle();
        checks++; if (rx_count !== 16'd1)      begin failures++; $display("FAIL mis_rx: got %0d want 1", rx_count); end
        checks++; if (misroute_error !== 1'b0) begin failures++; $display("FAIL mis_early: got %0b want 0", misroute_error); end
        step();
        step();
        checks++; if (misroute_error !== 1'b1) begin failures++; $display("FAIL mis_flag: got %0b want 1", misroute_error); end
        checks++; if (meas_count !== 16'd0)    begin failures++; $display("FAIL mis_meas: got %0d want 0", meas_count); end
        checks++; if (lat_sum !== 40'd0)       begin failures++; $display("FAIL mis_sum: got %0d want 0", lat_sum); end
    endtask

    task automatic test_reset_mid();
        apply_reset(8'd3);
        for (int c = 0; c < 8; c++) begin
            send(NET_DEST_W'(PORT_NO), 1'b1, timestamp);
            exp_q.push_back(24'(1 + 3 * c));
            step();
        end
        idle();
        step();
        step();                              // cycle 10: 5 buffered, entry 2 in stage 1
        checks++; if (lat_sum !== 40'd5)  begin failures++; $display("FAIL mid_pre: lat_sum=%0d want 5", lat_sum); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rx_count !== 16'd0 || meas_count !== 16'd0)
            begin failures++; $display("FAIL mid_cnt: rx=%0d meas=%0d want 0", rx_count, meas_count); end
        checks++; if (lat_sum !== 40'd0 || lat_max !== 24'd0)
            begin failures++; $display("FAIL mid_stats: sum=%0d max=%0d want 0", lat_sum, lat_max); end
        checks++; if ({sink_full, misroute_error, overflow_error} !== 3'b000)
            begin failures++; $display("FAIL mid_flags: got %b want 000", {sink_full, misroute_error, overflow_error}); end
        step();
        exp_q.delete();
        rst = 1'b0;
        step();
        send(NET_DEST_W'(PORT_NO), 1'b1, timestamp - 24'd9);
        exp_q.push_back(24'd10);
        step();
        idle();
        step();
        step();
        checks++; if (lat_sum !== 40'd10) begin failures++; $display("FAIL post_sum: got %0d want 10", lat_sum); end
        checks++; if (lat_max !== 24'd10) begin failures++; $display("FAIL post_max: got %0d want 10", lat_max); end
        checks++; if (rx_count !== 16'd1 || meas_count !== 16'd1)
            begin failures++; $display("FAIL post_cnt: rx=%0d meas=%0d want 1", rx_count, meas_count); end
        checks++; if ({misroute_error, overflow_error} !== 2'b00)
            begin failures++; $display("FAIL post_err: got %b want 00", {misroute_error, overflow_error}); end
    endtask

    initial begin
        rst          = 1'b1;
        timestamp    = 24'd0;
        drain_period = 8'd0;
        pkt_in       = '0;
        mon_prev_sum = 40'd0;
        mon_max      = 24'd0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_well_behaved();
        test_push_pop();
        test_misroute();
        test_reset_mid();
        step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL final_drain: %0d packets never observed", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_sink_stats.md
# packet_sink_stats

Ejection-side endpoint for one network output port. It accepts `packet_t` packets leaving the network and buffers them in a small ejection FIFO. The FIFO is drained at a programmable rate to model a slow consumer, and backpressure is applied to the network when the FIFO is full. For every drained packet the block checks its destination and measures end-to-end latency from the 24-bit injection timestamp carried in `data`. It accumulates the count, sum and maximum statistics used by the testbench report.

## Interface
Parameters:
- `port_no`, default 0: port index this sink serves. Packets are expected with `dest == port_no`.
- `PORTS`, default 16: network port count. The `dest` width is `log2(PORTS)`.
- `DEPTH`, default 8: ejection FIFO depth. Must be a power of 2, ≥ 2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `timestamp`, in, 24: global cycle counter, shared with the sources.
- `drain_period`, in, 8: pop at most one entry every `drain_period+1` cycles. 0 = every cycle. Quasi-static.
- `pkt_in`, in, `packet_t`: packet from the network. Only `valid`, `dest`, `data[23:0]` and `measure` are used.
- `sink_full`, out, 1: backpressure to the network. Combinational, `= (occupancy == DEPTH)`.
- `rx_count`, out, 16: packets accepted. Wraps.
- `meas_count`, out, 16: accepted packets with `measure=1`. Wraps.
- `lat_sum`, out, 40: sum of latencies of drained `measure=1` packets. Saturates at all-ones.
- `lat_max`, out, 24: maximum latency of drained `measure=1` packets.
- `misroute_error`, out, 1: sticky. A drained packet had `dest != port_no`.
- `overflow_error`, out, 1: sticky. `pkt_in.valid` was seen while `sink_full`.

## Operation
- **Accept.** When `pkt_in.valid && !sink_full`, write `{dest, measure, data[23:0]}` into the FIFO. Increment `rx_count`; also increment `meas_count` if `measure=1`.
- **Drop.** When `pkt_in.valid && sink_full`, discard the packet. Counters do not change; set `overflow_error`. This holds even if a pop occurs in the same cycle, because `sink_full` is taken from the pre-edge occupancy.
- **Drain counter `dcnt`** (8 bits):
  - A pop occurs in a cycle where FIFO is non-empty and `dcnt == drain_period`. `dcnt` then goes to 0.
  - While non-empty and `dcnt < drain_period`, `dcnt` increments.
  - While empty, `dcnt` is forced to `drain_period`, so the first packet after idle pops at the earliest opportunity.
  - If `drain_period` is changed below `dcnt`, treat the condition `dcnt >= drain_period` as a pop condition.
- **FIFO.** Not fall-through: an entry written at edge E is poppable no earlier than the cycle after E. Simultaneous push and pop is legal at any occupancy below `DEPTH`; occupancy is unchanged. Pointers wrap modulo `DEPTH`; occupancy counter width is `log2(DEPTH)+1`.
- **Latency.** `lat = (timestamp - data) mod 2^24`, using `timestamp` in the pop cycle. This is unsigned 24-bit wrap-around subtraction, so wrap of `timestamp` past 2^24−1 gives the correct small value.
- **Stats pipeline.**
  - Stage 1 (pop edge): register `lat`, `measure` and the `dest`-mismatch flag.
  - Stage 2 (next edge): if `measure=1`, update `lat_sum` (saturating add of zero-extended `lat`) and `lat_max`; set `misroute_error` on mismatch regardless of `measure`.
  - The pipeline accepts one entry per cycle, back to back.
- **Reset mid-operation.** The FIFO is emptied, in-flight stage-1 data is discarded, and all outputs are cleared.

## Timing
- Reset values: `rx_count=0`, `meas_count=0`, `lat_sum=0`, `lat_max=0`, `misroute_error=0`, `overflow_error=0`, occupancy 0 (hence `sink_full=0`), `dcnt=drain_period`-equivalent.
- `rx_count` and `meas_count` update on the accept edge.
- Minimum residency is 1 cycle. With `drain_period=0`, a packet accepted in the cycle where `timestamp=t` pops in cycle `t+1`.
- `lat_sum` and `lat_max` reflect a packet 2 edges after its pop cycle begins, i.e. visible in cycle `pop+2`.
- The `sink_full` → `valid` turnaround is zero cycles. The network samples `sink_full` in the same cycle it drives `valid`.
- Sustained throughput is one packet per `drain_period+1` cycles.

## Test plan
- **Single packet, no drain delay.** Reset; `drain_period=0`; one packet `dest=port_no`, `data=100`, `measure=1` accepted at `timestamp=105` → `rx_count=1`, `meas_count=1`, pop at 106, `lat_sum=6`, `lat_max=6` from cycle 108; no errors.
- **Timestamp wrap.** `data=24'hFFFFFE`, popped at `timestamp=3` → `lat=5`, `lat_sum=5`.
- **Backpressure and drop.** `DEPTH=8`, `drain_period=3`, valid every cycle:
  - `sink_full` rises after 8 occupancy.
  - Pops are spaced 4 cycles apart.
  - A `valid` held during `sink_full` → `overflow_error=1` and `rx_count` excludes that packet.
  - The well-behaved network case (valid gated by `sink_full`) never sets the flag.
- **Simultaneous push/pop at `DEPTH-1`.** Occupancy stays `DEPTH-1`, `sink_full` stays 0, FIFO order is preserved. Check latencies in order.
- **Misroute and unmeasured packets.** Packet `dest=port_no+1`, `measure=0` → `misroute_error=1`, `meas_count` and `lat_sum` unchanged, `rx_count` increments.
- **Reset mid-stream.** Assert `rst` asynchronously with 5 packets buffered and one in stage 1 → all outputs 0 immediately. After release, a new packet yields correct stats with no residue from before reset.
